// File: rtl/ysyx_2022040010_uncache_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_2022040010_uncache_ctrl_if : LSU-side and bus-side handshakes    |
// | of the uncached-access controller.            Revision: 1.0          |
// +----------------------------------------------------------------------+
interface ysyx_2022040010_uncache_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic                cpu_req_valid;
  logic                cpu_req_ready;
  logic                cpu_req_we;
  logic [ADDR_W-1:0]   cpu_req_addr;
  logic [DATA_W-1:0]   cpu_req_wdata;
  logic [DATA_W/8-1:0] cpu_req_wstrb;
  logic                cpu_resp_valid;
  logic [DATA_W-1:0]   cpu_resp_rdata;
  logic                cpu_resp_err;

  logic                bus_req_valid;
  logic                bus_req_ready;
  logic                bus_req_we;
  logic [ADDR_W-1:0]   bus_req_addr;
  logic [DATA_W-1:0]   bus_req_wdata;
  logic [DATA_W/8-1:0] bus_req_wstrb;
  logic                bus_resp_valid;
  logic [DATA_W-1:0]   bus_resp_rdata;
  logic                bus_resp_err;

  // Controller view: serves the LSU, drives the bus.
  modport slave (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, cpu_req_wstrb,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_err,
    output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb,
    input  bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
  );

  // Environment view: the LSU and the AXI bridge.
  modport master (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, cpu_req_wstrb,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, cpu_resp_err,
    input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb,
    output bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_2022040010_uncache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_2022040010_uncache_ctrl : uncached MMIO access controller with   |
// | optional posted-write FIFO (macro UNCACHE_POSTED_WR_EN). Revision 1.0 |
// +----------------------------------------------------------------------+
module ysyx_2022040010_uncache_ctrl #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  ysyx_2022040010_uncache_ctrl_if.slave  io,
  output logic                           wbuf_empty,
  output logic                           wr_err_sticky
);
  localparam int STRB_W = DATA_W / 8;

  if ((DATA_W % 8) != 0 || WBUF_DEPTH < 2 || (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_param_check
    $error("uncache_ctrl: illegal DATA_W or WBUF_DEPTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                launch_we_q, launch_we_d;
  logic [ADDR_W-1:0]   launch_addr_q, launch_addr_d;
  logic [DATA_W-1:0]   launch_wdata_q, launch_wdata_d;
  logic [STRB_W-1:0]   launch_wstrb_q, launch_wstrb_d;
  logic                bus_req_valid_q, bus_req_valid_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic                cpu_fire;
  logic                bus_resp_fire;

  assign cpu_fire      = io.cpu_req_valid & io.cpu_req_ready;
  assign bus_resp_fire = (state_q == WAIT) & io.bus_resp_valid;

  assign io.bus_req_valid  = bus_req_valid_q;
  assign io.bus_req_we     = launch_we_q;
  assign io.bus_req_addr   = launch_addr_q;
  assign io.bus_req_wdata  = launch_wdata_q;
  assign io.bus_req_wstrb  = launch_wstrb_q;
  assign io.cpu_resp_valid = resp_valid_q;
  assign io.cpu_resp_rdata = resp_rdata_q;
  assign io.cpu_resp_err   = resp_err_q;

`ifdef UNCACHE_POSTED_WR_EN
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W + STRB_W;

  logic [ENT_W-1:0] mem_q [WBUF_DEPTH];
  logic [ENT_W-1:0] mem_d [WBUF_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             sticky_q, sticky_d;
  logic             fifo_empty, fifo_full, push, pop, rd_resp_next;

  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full    = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &
                        (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  // A write ack accepted now lands next cycle; keep it off a read's RESP pulse.
  assign rd_resp_next = bus_resp_fire & ~launch_we_q;
  assign io.cpu_req_ready = ~rst & (io.cpu_req_we ? (~fifo_full & ~rd_resp_next)
                                                  : ((state_q == IDLE) & fifo_empty));
  assign push          = cpu_fire & io.cpu_req_we;
  assign pop           = (state_q == IDLE) & ~fifo_empty;
  assign wbuf_empty    = fifo_empty & ((state_q == IDLE) | ~launch_we_q);
  assign wr_err_sticky = sticky_q;

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = {io.cpu_req_addr, io.cpu_req_wdata, io.cpu_req_wstrb};
    end
    wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    sticky_d = sticky_q | (bus_resp_fire & launch_we_q & io.bus_resp_err);
  end
`else
  assign io.cpu_req_ready = ~rst & (state_q == IDLE);
  assign wbuf_empty       = 1'b1;
  assign wr_err_sticky    = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    launch_we_d    = launch_we_q;
    launch_addr_d  = launch_addr_q;
    launch_wdata_d = launch_wdata_q;
    launch_wstrb_d = launch_wstrb_q;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = '0;
    resp_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef UNCACHE_POSTED_WR_EN
        if (pop) begin
          state_d     = ISSUE;
          launch_we_d = 1'b1;
          {launch_addr_d, launch_wdata_d, launch_wstrb_d} = mem_q[rd_ptr_q[PTR_W-1:0]];
        end else if (cpu_fire & ~io.cpu_req_we) begin
`else
        if (cpu_fire) begin
`endif
          state_d        = ISSUE;
          launch_we_d    = io.cpu_req_we;
          launch_addr_d  = io.cpu_req_addr;
          launch_wdata_d = io.cpu_req_wdata;
          launch_wstrb_d = io.cpu_req_wstrb;
        end
      end
      ISSUE:   if (io.bus_req_ready)  state_d = WAIT;
      WAIT:    if (io.bus_resp_valid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef UNCACHE_POSTED_WR_EN
    if (bus_resp_fire & ~launch_we_q) begin
      resp_valid_d = 1'b1;
      resp_rdata_d = io.bus_resp_rdata;
      resp_err_d   = io.bus_resp_err;
    end
    if (push) resp_valid_d = 1'b1;
`else
    if (bus_resp_fire) begin
      resp_valid_d = 1'b1;
      resp_rdata_d = launch_we_q ? '0 : io.bus_resp_rdata;
      resp_err_d   = io.bus_resp_err;
    end
`endif
    bus_req_valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      launch_we_q     <= 1'b0;
      launch_addr_q   <= '0;
      launch_wdata_q  <= '0;
      launch_wstrb_q  <= '0;
      bus_req_valid_q <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_err_q      <= 1'b0;
`ifdef UNCACHE_POSTED_WR_EN
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      sticky_q        <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      launch_we_q     <= launch_we_d;
      launch_addr_q   <= launch_addr_d;
      launch_wdata_q  <= launch_wdata_d;
      launch_wstrb_q  <= launch_wstrb_d;
      bus_req_valid_q <= bus_req_valid_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_err_q      <= resp_err_d;
`ifdef UNCACHE_POSTED_WR_EN
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      sticky_q        <= sticky_d;
`endif
    end
`ifdef UNCACHE_POSTED_WR_EN
    mem_q <= mem_d;
`endif
  end
endmodule
`default_nettype wire

// File: tb/tb_ysyx_2022040010_uncache_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ysyx_2022040010_uncache_ctrl : directed bench for the uncached     |
// | controller (both UNCACHE_POSTED_WR_EN builds).        Revision 1.0   |
// +----------------------------------------------------------------------+
module tb_ysyx_2022040010_uncache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wbuf_empty, wr_err_sticky;
  int   n_checks = 0;
  int   n_errors = 0;

  ysyx_2022040010_uncache_ctrl_if #(.DATA_W(64), .ADDR_W(32)) io ();

  ysyx_2022040010_uncache_ctrl #(.DATA_W(64), .ADDR_W(32), .WBUF_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .io            (io),
    .wbuf_empty    (wbuf_empty),
    .wr_err_sticky (wr_err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic we, input logic [31:0] addr,
                           input logic [63:0] wdata, input logic [7:0] wstrb);
    io.cpu_req_valid = 1'b1;
    io.cpu_req_we    = we;
    io.cpu_req_addr  = addr;
    io.cpu_req_wdata = wdata;
    io.cpu_req_wstrb = wstrb;
  endtask

  // Waits (bounded) for a bus request, checks it, completes handshake and
  // response; returns in the RESP cycle.
  task automatic bus_serve(input string tag, input logic [31:0] eaddr, input logic ewe,
                           input logic [63:0] rdata, input logic err);
    int n = 0;
    while (!io.bus_req_valid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_req_valid"}, 64'(io.bus_req_valid), 64'd1);
    chk({tag, "_req_addr"},  64'(io.bus_req_addr), 64'(eaddr));
    chk({tag, "_req_we"},    64'(io.bus_req_we), 64'(ewe));
    io.bus_req_ready = 1'b1;
    tick();
    io.bus_req_ready  = 1'b0;
    io.bus_resp_valid = 1'b1;
    io.bus_resp_rdata = rdata;
    io.bus_resp_err   = err;
    tick();
    io.bus_resp_valid = 1'b0;
    io.bus_resp_rdata = '0;
    io.bus_resp_err   = 1'b0;
  endtask

  initial begin
    io.cpu_req_valid  = 1'b0;
    io.cpu_req_we     = 1'b0;
    io.cpu_req_addr   = '0;
    io.cpu_req_wdata  = '0;
    io.cpu_req_wstrb  = '0;
    io.bus_req_ready  = 1'b0;
    io.bus_resp_valid = 1'b0;
    io.bus_resp_rdata = '0;
    io.bus_resp_err   = 1'b0;

    // Reset values; a request during reset must not be accepted.
    cpu_drive(1'b0, 32'h1000_0000, 64'd0, 8'h00);
    repeat (3) tick();
    chk("rst_ready",      64'(io.cpu_req_ready), 64'd0);
    chk("rst_resp_valid", 64'(io.cpu_resp_valid), 64'd0);
    chk("rst_resp_rdata", io.cpu_resp_rdata, 64'd0);
    chk("rst_resp_err",   64'(io.cpu_resp_err), 64'd0);
    chk("rst_bus_valid",  64'(io.bus_req_valid), 64'd0);
    chk("rst_wbuf_empty", 64'(wbuf_empty), 64'd1);
    chk("rst_sticky",     64'(wr_err_sticky), 64'd0);
    rst = 1'b0;
    io.cpu_req_valid = 1'b0;
    tick();

    // Best-case read: accept T, ISSUE T+1, WAIT T+2, response T+3.
    io.bus_req_ready = 1'b1;
    cpu_drive(1'b0, 32'h1000_0000, 64'd0, 8'h00);
    chk("rd_ready", 64'(io.cpu_req_ready), 64'd1);
    tick();
    io.cpu_req_valid = 1'b0;
    chk("rd_issue_valid", 64'(io.bus_req_valid), 64'd1);
    chk("rd_issue_addr",  64'(io.bus_req_addr), 64'h1000_0000);
    chk("rd_issue_we",    64'(io.bus_req_we), 64'd0);
    chk("rd_t1_resp",     64'(io.cpu_resp_valid), 64'd0);
    tick();
    chk("rd_wait_bus_valid", 64'(io.bus_req_valid), 64'd0);
    chk("rd_t2_resp",        64'(io.cpu_resp_valid), 64'd0);
    chk("rd_t2_rdata",       io.cpu_resp_rdata, 64'd0);
    io.bus_resp_valid = 1'b1;
    io.bus_resp_rdata = 64'hDEAD_BEEF_0123_4567;
    tick();
    io.bus_resp_valid = 1'b0;
    io.bus_resp_rdata = '0;
    io.bus_req_ready  = 1'b0;
    chk("rd_t3_resp",  64'(io.cpu_resp_valid), 64'd1);
    chk("rd_t3_rdata", io.cpu_resp_rdata, 64'hDEAD_BEEF_0123_4567);
    chk("rd_t3_err",   64'(io.cpu_resp_err), 64'd0);
    tick();
    chk("rd_t4_resp",  64'(io.cpu_resp_valid), 64'd0);
    chk("rd_t4_rdata", io.cpu_resp_rdata, 64'd0);

    // Read with a stalled bus and an error response.
    cpu_drive(1'b0, 32'h1000_0010, 64'd0, 8'h00);
    tick();
    io.cpu_req_valid = 1'b0;
    tick();
    chk("stall_valid", 64'(io.bus_req_valid), 64'd1);
    chk("stall_addr",  64'(io.bus_req_addr), 64'h1000_0010);
    bus_serve("rderr", 32'h1000_0010, 1'b0, 64'h0BAD_0BAD_0BAD_0BAD, 1'b1);
    chk("rderr_valid", 64'(io.cpu_resp_valid), 64'd1);
    chk("rderr_err",   64'(io.cpu_resp_err), 64'd1);
    chk("rderr_rdata", io.cpu_resp_rdata, 64'h0BAD_0BAD_0BAD_0BAD);
    tick();
    chk("rderr_err_after", 64'(io.cpu_resp_err), 64'd0);

`ifndef UNCACHE_POSTED_WR_EN
    // Non-posted write: payload on the bus, ack only in RESP.
    cpu_drive(1'b1, 32'h1000_0008, 64'h1122_3344_5566_7788, 8'h0F);
    chk("wr_ready", 64'(io.cpu_req_ready), 64'd1);
    tick();
    chk("wr_busy_ready", 64'(io.cpu_req_ready), 64'd0);
    io.cpu_req_valid = 1'b0;
    chk("wr_we",    64'(io.bus_req_we), 64'd1);
    chk("wr_wstrb", 64'(io.bus_req_wstrb), 64'h0F);
    chk("wr_wdata", io.bus_req_wdata, 64'h1122_3344_5566_7788);
    chk("wr_issue_resp", 64'(io.cpu_resp_valid), 64'd0);
    io.bus_req_ready = 1'b1;
    tick();
    io.bus_req_ready = 1'b0;
    chk("wr_wait_resp", 64'(io.cpu_resp_valid), 64'd0);
    io.bus_resp_valid = 1'b1;
    io.bus_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    io.bus_resp_valid = 1'b0;
    io.bus_resp_rdata = '0;
    chk("wr_ack_valid", 64'(io.cpu_resp_valid), 64'd1);
    chk("wr_ack_rdata", io.cpu_resp_rdata, 64'd0);
    chk("wr_ack_err",   64'(io.cpu_resp_err), 64'd0);
    tick();
    cpu_drive(1'b1, 32'h1000_0020, 64'h5A5A, 8'hFF);
    tick();
    io.cpu_req_valid = 1'b0;
    bus_serve("wrerr", 32'h1000_0020, 1'b1, 64'h1234, 1'b1);
    chk("wrerr_valid", 64'(io.cpu_resp_valid), 64'd1);
    chk("wrerr_err",   64'(io.cpu_resp_err), 64'd1);
    chk("wrerr_rdata", io.cpu_resp_rdata, 64'd0);
    chk("np_wbuf_empty", 64'(wbuf_empty), 64'd1);
    chk("np_sticky",     64'(wr_err_sticky), 64'd0);
    tick();

    // Reset while waiting for a read response; the late response is dropped.
    cpu_drive(1'b0, 32'h1000_0030, 64'd0, 8'h00);
    io.bus_req_ready = 1'b1;
    tick();
    io.cpu_req_valid = 1'b0;
    tick();
    io.bus_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_bus_valid", 64'(io.bus_req_valid), 64'd0);
    io.bus_resp_valid = 1'b1;
    io.bus_resp_rdata = 64'h7777;
    tick();
    io.bus_resp_valid = 1'b0;
    chk("mrst_no_resp", 64'(io.cpu_resp_valid), 64'd0);
    chk("mrst_rdata",   io.cpu_resp_rdata, 64'd0);
`else
    // Posted writes with a stalled bus: one launched plus four buffered.
    for (int i = 0; i < 5; i++) begin
      cpu_drive(1'b1, 32'h2000_0000 + 32'(i * 8), 64'(i + 1), 8'hFF);
      chk("pw_ready", 64'(io.cpu_req_ready), 64'd1);
      tick();
      chk("pw_ack", 64'(io.cpu_resp_valid), 64'd1);
      chk("pw_ack_rdata", io.cpu_resp_rdata, 64'd0);
    end
    cpu_drive(1'b1, 32'h2000_0100, 64'd9, 8'hFF);
    chk("pw_full_ready", 64'(io.cpu_req_ready), 64'd0);
    chk("pw_wbuf_busy",  64'(wbuf_empty), 64'd0);
    tick();
    io.cpu_req_valid = 1'b0;
    chk("pw_no_ack", 64'(io.cpu_resp_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      bus_serve("pw_drain", 32'h2000_0000 + 32'(i * 8), 1'b1, 64'd0, 1'b0);
      chk("pw_drain_nocpu", 64'(io.cpu_resp_valid), 64'd0);
    end
    tick();
    chk("pw_wbuf_empty", 64'(wbuf_empty), 64'd1);
    chk("pw_sticky0",    64'(wr_err_sticky), 64'd0);

    // Write then read: the read waits for the write's bus response.
    cpu_drive(1'b1, 32'h2000_0200, 64'hAB, 8'h01);
    tick();
    cpu_drive(1'b0, 32'h2000_0300, 64'd0, 8'h00);
    chk("wr_rd_held", 64'(io.cpu_req_ready), 64'd0);
    bus_serve("wr_rd_w", 32'h2000_0200, 1'b1, 64'd0, 1'b1);
    chk("wr_rd_held2", 64'(io.cpu_req_ready), 64'd0);
    tick();
    chk("sticky_set", 64'(wr_err_sticky), 64'd1);
    chk("wr_rd_ready", 64'(io.cpu_req_ready), 64'd1);
    chk("wr_rd_empty", 64'(wbuf_empty), 64'd1);
    tick();
    io.cpu_req_valid = 1'b0;
    bus_serve("wr_rd_r", 32'h2000_0300, 1'b0, 64'hCAFE, 1'b0);
    chk("wr_rd_rdata", io.cpu_resp_rdata, 64'hCAFE);
    tick();
    chk("sticky_hold", 64'(wr_err_sticky), 64'd1);

    // Reset in WAIT with two buffered writes: everything is discarded.
    for (int i = 0; i < 3; i++) begin
      cpu_drive(1'b1, 32'h2000_0400 + 32'(i * 8), 64'(i), 8'hFF);
      tick();
    end
    io.cpu_req_valid = 1'b0;
    io.bus_req_ready = 1'b1;
    tick();
    io.bus_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_bus_valid", 64'(io.bus_req_valid), 64'd0);
    chk("mrst_wbuf",      64'(wbuf_empty), 64'd1);
    chk("mrst_sticky",    64'(wr_err_sticky), 64'd0);
    io.bus_resp_valid = 1'b1;
    tick();
    io.bus_resp_valid = 1'b0;
    chk("mrst_no_resp", 64'(io.cpu_resp_valid), 64'd0);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
        tick();
        seen = seen | io.bus_req_valid;
      end
      chk("mrst_no_drain", 64'(seen), 64'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
